// File: rtl/complex_result_buffer.sv
// Result FIFO between the complex multiplier and its consumer; narrows each component RES_W -> OUT_W on write.
// Optional feature: define RESULT_SATURATE_EN for saturating narrowing plus a sticky clip counter (sat_cnt).
module complex_result_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_W      = 2*DATA_WIDTH+1,
    parameter int OUT_W      = 16,
    parameter int DEPTH      = 4,
    localparam int CNT_W     = $clog2(DEPTH+1),
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    sw_rst,
    input  logic                    res_val,
    output logic                    res_ready,
    input  logic signed [RES_W-1:0] res_re,
    input  logic signed [RES_W-1:0] res_im,
    output logic                    out_val,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic [CNT_W-1:0]        count,
    output logic [7:0]              sat_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_t;

    occ_t             occ;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    logic signed [OUT_W-1:0] mem_re [DEPTH];
    logic signed [OUT_W-1:0] mem_im [DEPTH];
    logic signed [OUT_W-1:0] nar_re;
    logic signed [OUT_W-1:0] nar_im;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy is a pure function of the registered count, so ready never sees out_ready.
    always_comb begin
        occ = EMPTY;
        if (count == CNT_W'(DEPTH))
            occ = FULL;
        else if (count != '0)
            occ = PARTIAL;
    end

    assign res_ready = (occ != FULL);
    assign out_val   = (occ != EMPTY);
    assign push      = res_val & res_ready;
    assign pop       = out_val & out_ready;

    assign out_re = out_val ? mem_re[rd_ptr] : '0;
    assign out_im = out_val ? mem_im[rd_ptr] : '0;

`ifdef RESULT_SATURATE_EN
    logic [RES_W-OUT_W:0] re_hi;
    logic [RES_W-OUT_W:0] im_hi;
    logic                 clip_re;
    logic                 clip_im;
    logic [8:0]           sat_sum;
    logic [7:0]           sat_q;

    // A value fits in OUT_W only if all bits from OUT_W-1 upward agree with the sign.
    always_comb begin
        re_hi   = res_re[RES_W-1:OUT_W-1];
        im_hi   = res_im[RES_W-1:OUT_W-1];
        clip_re = !((&re_hi) || !(|re_hi));
        clip_im = !((&im_hi) || !(|im_hi));
        nar_re  = res_re[OUT_W-1:0];
        nar_im  = res_im[OUT_W-1:0];
        if (clip_re)
            nar_re = res_re[RES_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        if (clip_im)
            nar_im = res_im[RES_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        sat_sum = {1'b0, sat_q} + {8'd0, clip_re} + {8'd0, clip_im};
    end

    always_ff @(posedge clk) begin
        if (sw_rst)
            sat_q <= '0;
        else if (push)
            sat_q <= sat_sum[8] ? 8'hFF : sat_sum[7:0];
    end

    assign sat_cnt = sat_q;
`else
    logic unused_hi;

    assign nar_re    = res_re[OUT_W-1:0];
    assign nar_im    = res_im[OUT_W-1:0];
    assign unused_hi = ^{res_re, res_im};
    assign sat_cnt   = '0;
`endif

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !sw_rst) begin
            mem_re[wr_ptr] <= nar_re;
            mem_im[wr_ptr] <= nar_im;
        end
    end

endmodule

// File: tb/tb_complex_result_buffer.sv
// Directed self-checking bench for complex_result_buffer (DEPTH=4, RES_W=17, OUT_W=16).
// Expected saturation results follow RESULT_SATURATE_EN when the bench is built with it.
module tb_complex_result_buffer;

    localparam int DATA_WIDTH = 8;
    localparam int RES_W      = 17;
    localparam int OUT_W      = 16;
    localparam int DEPTH      = 4;
    localparam int CNT_W      = $clog2(DEPTH+1);

    logic                    clk = 1'b0;
    logic                    sw_rst = 1'b0;
    logic                    res_val = 1'b0;
    logic                    res_ready;
    logic signed [RES_W-1:0] res_re = '0;
    logic signed [RES_W-1:0] res_im = '0;
    logic                    out_val;
    logic                    out_ready = 1'b0;
    logic signed [OUT_W-1:0] out_re;
    logic signed [OUT_W-1:0] out_im;
    logic [CNT_W-1:0]        count;
    logic [7:0]              sat_cnt;

    int checks = 0;
    int errors = 0;

    complex_result_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .RES_W(RES_W),
        .OUT_W(OUT_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .sw_rst(sw_rst),
        .res_val(res_val),
        .res_ready(res_ready),
        .res_re(res_re),
        .res_im(res_im),
        .out_val(out_val),
        .out_ready(out_ready),
        .out_re(out_re),
        .out_im(out_im),
        .count(count),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, then lands 1ns past the edge for sampling.
    task automatic applyStimulus(input logic val, input int re, input int im,
                                 input logic ordy, input logic rst);
        res_val   = val;
        res_re    = RES_W'(re);
        res_im    = RES_W'(im);
        out_ready = ordy;
        sw_rst    = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input int re, input int im);
        checkOutput({tag, "_val"}, int'(out_val), 1);
        checkOutput({tag, "_re"}, int'(out_re), re);
        checkOutput({tag, "_im"}, int'(out_im), im);
    endtask

    int exp_sat_re, exp_sat_im, exp_clip;

    initial begin
`ifdef RESULT_SATURATE_EN
        exp_sat_re = 32767;
        exp_sat_im = -32768;
        exp_clip   = 2;
`else
        exp_sat_re = -32768;
        exp_sat_im = 32767;
        exp_clip   = 0;
`endif
        $display("[TB] start");

        // Reset
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_out_val", int'(out_val), 0);
        checkOutput("rst_res_ready", int'(res_ready), 1);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_out_re", int'(out_re), 0);
        checkOutput("rst_out_im", int'(out_im), 0);
        checkOutput("rst_sat_cnt", int'(sat_cnt), 0);

        // Single push, then one pop
        applyStimulus(1, 100, -50, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkHead("single", 100, -50);
        checkOutput("single_count", int'(count), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("single_pop_val", int'(out_val), 0);
        checkOutput("single_pop_count", int'(count), 0);

        // Fill to DEPTH, hold a fifth result against a full buffer
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, i, -i, 0, 0);
        checkOutput("full_count", int'(count), 4);
        checkOutput("full_ready", int'(res_ready), 0);
        applyStimulus(1, 5, -5, 0, 0);
        checkOutput("held_count", int'(count), 4);
        checkOutput("held_ready", int'(res_ready), 0);
        checkHead("full_head", 1, -1);
        applyStimulus(1, 5, -5, 1, 0);
        checkOutput("pop_full_count", int'(count), 3);
        checkOutput("pop_full_ready", int'(res_ready), 1);
        applyStimulus(1, 5, -5, 0, 0);
        checkOutput("fifth_count", int'(count), 4);
        res_val = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            checkHead($sformatf("order%0d", k), k, -k);
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("drain_count", int'(count), 0);

        // Simultaneous push/pop at count=2, read pointer wraps 3->0
        applyStimulus(1, 10, -10, 0, 0);
        applyStimulus(1, 11, -11, 0, 0);
        checkOutput("sim_pre_count", int'(count), 2);
        checkHead("sim_h0", 10, -10);
        applyStimulus(1, 12, -12, 1, 0);
        checkOutput("sim1_count", int'(count), 2);
        checkHead("sim_h1", 11, -11);
        applyStimulus(1, 13, -13, 1, 0);
        checkOutput("sim2_count", int'(count), 2);
        checkHead("sim_h2", 12, -12);
        applyStimulus(0, 0, 0, 1, 0);
        checkHead("sim_h3", 13, -13);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sim_drain_count", int'(count), 0);

        // Narrowing at the OUT_W boundary
        applyStimulus(1, 32768, -32769, 0, 0);
        applyStimulus(1, -32768, 32767, 0, 0);
        checkHead("narrow", exp_sat_re, exp_sat_im);
        checkOutput("narrow_sat_cnt", int'(sat_cnt), exp_clip);
        applyStimulus(0, 0, 0, 1, 0);
        checkHead("fit", -32768, 32767);
        checkOutput("fit_sat_cnt", int'(sat_cnt), exp_clip);
        applyStimulus(0, 0, 0, 1, 0);

        // Reset at count=3 while both handshakes are active
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 20 + i, 0, 0, 0);
        checkOutput("mid_pre_count", int'(count), 3);
        applyStimulus(1, 99, 99, 1, 1);
        checkOutput("mid_rst_count", int'(count), 0);
        checkOutput("mid_rst_val", int'(out_val), 0);
        checkOutput("mid_rst_sat", int'(sat_cnt), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid_after_count", int'(count), 0);
        checkOutput("mid_after_re", int'(out_re), 0);

        // Clip counter sticks at 255 (stays 0 in the truncating build)
        for (int i = 0; i < 127; i++)
            applyStimulus(1, 32768, -32769, 1, 0);
        checkOutput("sat_254", int'(sat_cnt), (exp_clip == 2) ? 254 : 0);
        applyStimulus(1, 32768, -32769, 1, 0);
        checkOutput("sat_255", int'(sat_cnt), (exp_clip == 2) ? 255 : 0);
        applyStimulus(1, 32768, -32769, 1, 0);
        checkOutput("sat_stick", int'(sat_cnt), (exp_clip == 2) ? 255 : 0);
        checkOutput("sat_stream_count", int'(count), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("final_count", int'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
